// File: rtl/vend_txn_ctrl.sv
// rtl/vend_txn_ctrl.sv - vending transaction controller: select, price check, coin collect, dispense, change
//
// Purpose
//   Sequences one vending transaction: latches a selection, waits for the
//   external item table to return stock/price, collects currency until the
//   price is met (or the user cancels), pulses a dispense, then presents any
//   change or refund until it is taken.
//
// Build option
//   VEND_TIMEOUT_EN - when defined, COLLECT abandons the transaction after
//                     TIMEOUT_CYCLES consecutive cycles without a currency
//                     transfer, pulsing timeout and refunding the balance.
//                     When undefined, COLLECT waits indefinitely and timeout
//                     is tied low.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   sel_valid/sel_id item selection strobe and index (sampled in IDLE only)
//   cur_valid/value  currency offered; cur_ready high only while collecting
//   cancel           user cancel, honoured only while collecting
//   item_id          lookup index to the item table, stable for the transaction
//   avail_count      stock of item_id (from table)
//   item_price       price of item_id (from table)
//   item_ready       item_id is configured (from table)
//   dispense         one-cycle stock-decrement pulse to the item table
//   disp_valid/id    one-cycle product-out pulse and dispensed item
//   sel_error        one-cycle reject pulse (unconfigured or out of stock)
//   change_valid/value/ready  change or refund handshake
//   timeout          one-cycle idle-collect timeout pulse

module vend_txn_ctrl #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int LOOKUP_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sel_valid,
  input  logic [ITEM_ADDR_WIDTH-1:0] sel_id,
  input  logic                       cur_valid,
  input  logic [7:0]                 cur_value,
  output logic                       cur_ready,
  input  logic                       cancel,
  output logic [ITEM_ADDR_WIDTH-1:0] item_id,
  input  logic [7:0]                 avail_count,
  input  logic [15:0]                item_price,
  input  logic                       item_ready,
  output logic                       dispense,
  output logic                       disp_valid,
  output logic [ITEM_ADDR_WIDTH-1:0] disp_id,
  output logic                       sel_error,
  output logic                       change_valid,
  output logic [16:0]                change_value,
  input  logic                       change_ready,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam int LK_W = $clog2(LOOKUP_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOOKUP_CYCLES - 1);

  state_t            state;
  logic [16:0]       balance;
  logic [LK_W-1:0]   lookup_cnt;

  // cur_ready is a registered copy of "state == COLLECT", so a transfer is
  // simply an offered coin while ready.
  logic              xfer;
  logic [16:0]       bal_next;
  logic [16:0]       change_calc;

  assign xfer        = cur_valid && cur_ready;
  assign bal_next    = balance + (xfer ? {9'd0, cur_value} : 17'd0);
  assign change_calc = balance - {1'b0, item_price};

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;
`else
  // The parameter stays on the interface so both builds share one port map.
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      balance      <= 17'd0;
      lookup_cnt   <= '0;
      item_id      <= '0;
      change_value <= 17'd0;
      cur_ready    <= 1'b0;
      dispense     <= 1'b0;
      disp_valid   <= 1'b0;
      disp_id      <= '0;
      sel_error    <= 1'b0;
      change_valid <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt     <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; they are raised for exactly one cycle.
      dispense   <= 1'b0;
      disp_valid <= 1'b0;
      sel_error  <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timeout    <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (sel_valid) begin
            item_id    <= sel_id;
            balance    <= 17'd0;
            lookup_cnt <= '0;
            state      <= LOOKUP;
          end
        end

        // Gives the item table time to return data for the new item_id.
        LOOKUP: begin
          if (lookup_cnt == LK_LAST) begin
            state <= CHECK;
          end else begin
            lookup_cnt <= lookup_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (!item_ready || (avail_count == 8'd0)) begin
            sel_error <= 1'b1;
            state     <= IDLE;
          end else if (item_price == 16'd0) begin
            // Free item: skip collection entirely.
            dispense   <= 1'b1;
            disp_valid <= 1'b1;
            disp_id    <= item_id;
            state      <= DISPENSE;
          end else begin
            cur_ready <= 1'b1;
`ifdef VEND_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            state     <= COLLECT;
          end
        end

        COLLECT: begin
          balance <= bal_next;
          // Cancel wins over reaching the price: a coin arriving with cancel
          // is refunded, never spent.
          if (cancel) begin
            change_value <= bal_next;
            change_valid <= (bal_next != 17'd0);
            cur_ready    <= 1'b0;
            state        <= CHANGE;
          end else if (bal_next >= {1'b0, item_price}) begin
            cur_ready  <= 1'b0;
            dispense   <= 1'b1;
            disp_valid <= 1'b1;
            disp_id    <= item_id;
            state      <= DISPENSE;
          end
`ifdef VEND_TIMEOUT_EN
          else if (xfer) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_LAST) begin
            // No transfer this cycle, so balance already holds the total.
            timeout      <= 1'b1;
            change_value <= balance;
            change_valid <= (balance != 17'd0);
            cur_ready    <= 1'b0;
            state        <= CHANGE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        // The dispense pulse is high during this state; settle the change.
        DISPENSE: begin
          change_value <= change_calc;
          change_valid <= (change_calc != 17'd0);
          state        <= CHANGE;
        end

        // Zero change leaves after one cycle; otherwise hold for the taker.
        CHANGE: begin
          if (!change_valid || change_ready) begin
            change_valid <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb/tb_vend_txn_ctrl.sv - self-checking bench for vend_txn_ctrl
module tb_vend_txn_ctrl;

  localparam int AW = 10;
  localparam int LK = 3;
  localparam int TO = 16;

  logic          clk;
  logic          rstn;
  logic          sel_valid;
  logic [AW-1:0] sel_id;
  logic          cur_valid;
  logic [7:0]    cur_value;
  logic          cur_ready;
  logic          cancel;
  logic [AW-1:0] item_id;
  logic [7:0]    avail_count;
  logic [15:0]   item_price;
  logic          item_ready;
  logic          dispense;
  logic          disp_valid;
  logic [AW-1:0] disp_id;
  logic          sel_error;
  logic          change_valid;
  logic [16:0]   change_value;
  logic          change_ready;
  logic          timeout;

  vend_txn_ctrl #(
    .ITEM_ADDR_WIDTH(AW),
    .LOOKUP_CYCLES  (LK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cur_valid   (cur_valid),
    .cur_value   (cur_value),
    .cur_ready   (cur_ready),
    .cancel      (cancel),
    .item_id     (item_id),
    .avail_count (avail_count),
    .item_price  (item_price),
    .item_ready  (item_ready),
    .dispense    (dispense),
    .disp_valid  (disp_valid),
    .disp_id     (disp_id),
    .sel_error   (sel_error),
    .change_valid(change_valid),
    .change_value(change_value),
    .change_ready(change_ready),
    .timeout     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Item table with a two-cycle read pipe.
  logic [15:0]   price_mem [0:1023];
  logic [7:0]    stock_mem [0:1023];
  logic          ready_mem [0:1023];
  logic [AW-1:0] tbl_addr;

  always @(posedge clk) begin
    tbl_addr    <= item_id;
    item_price  <= price_mem[tbl_addr];
    avail_count <= stock_mem[tbl_addr];
    item_ready  <= ready_mem[tbl_addr];
  end

  // Output monitor: counts high cycles of each pulse-type output.
  int n_disp = 0, n_dv = 0, n_err = 0, n_to = 0, n_cv = 0;
  int last_disp_id = -1;

  always @(negedge clk) begin
    if (dispense)     n_disp <= n_disp + 1;
    if (disp_valid) begin
      n_dv         <= n_dv + 1;
      last_disp_id <= int'(disp_id);
    end
    if (sel_error)    n_err <= n_err + 1;
    if (timeout)      n_to  <= n_to + 1;
    if (change_valid) n_cv  <= n_cv + 1;
  end

  int nchecks = 0;
  int nerrs   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Coin list of the transaction being driven; cancel_idx marks the coin
  // that is offered together with cancel (-1 for none).
  int coins[8];
  int ncoins;
  int cancel_idx;

  // Transaction-level reference: outcome from the selling rules alone.
  // Coins left unspent when the list runs out are refunded by the closing
  // cancel the driver issues.
  function automatic void model(input bit rdy, input int stock, input int price,
                                output bit err, output bit disp, output int chg);
    int  bal;
    bit  done;
    err = 1'b0; disp = 1'b0; chg = 0; bal = 0; done = 1'b0;
    if (!rdy || stock == 0) begin
      err = 1'b1;
      return;
    end
    if (price == 0) begin
      disp = 1'b1;
      return;
    end
    for (int i = 0; i < ncoins && !done; i++) begin
      bal += coins[i];
      if (i == cancel_idx) begin
        chg  = bal;
        done = 1'b1;
      end else if (bal >= price) begin
        disp = 1'b1;
        chg  = bal - price;
        done = 1'b1;
      end
    end
    if (!done) chg = bal;
  endfunction

  task automatic clear_inputs();
    sel_valid = 1'b0;
    cur_valid = 1'b0;
    cancel    = 1'b0;
  endtask

  task automatic run_txn(input int id, input bit rdy, input int stock, input int price,
                         input bit e_err, input bit e_disp, input int e_chg, input string tag);
    int s_disp, s_dv, s_err, s_to;
    bit saw_ready, seen, stable;
    int i, guard, hold;
    logic [16:0] v;

    price_mem[id] = 16'(price);
    stock_mem[id] = 8'(stock);
    ready_mem[id] = rdy;
    s_disp = n_disp; s_dv = n_dv; s_err = n_err; s_to = n_to;

    sel_valid = 1'b1;
    sel_id    = AW'(id);
    @(negedge clk);
    sel_valid = 1'b0;

    // Noise while the controller is still in LOOKUP must be ignored.
    saw_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cur_ready) begin
        saw_ready = 1'b1;
        break;
      end
      if (k < 3) begin
        sel_valid = 1'($urandom_range(0, 1));
        sel_id    = AW'($urandom);
        cur_valid = 1'($urandom_range(0, 1));
        cur_value = 8'($urandom);
        cancel    = 1'($urandom_range(0, 1));
      end else begin
        clear_inputs();
      end
      @(negedge clk);
    end
    clear_inputs();

    i = 0;
    guard = 0;
    while (cur_ready && i < ncoins && guard < 64) begin
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        cur_valid = 1'b0;
        cancel    = 1'b0;
        sel_valid = 1'($urandom_range(0, 1));
        sel_id    = AW'($urandom);
      end else begin
        sel_valid = 1'b0;
        cur_valid = 1'b1;
        cur_value = 8'(coins[i]);
        cancel    = (i == cancel_idx);
        i++;
      end
      @(negedge clk);
    end
    clear_inputs();
    if (cur_ready) begin
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
    end

    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (change_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_change_seen"}, 64'(seen), 64'(e_chg != 0));
    if (seen) begin
      v = change_value;
      check({tag, "_change_value"}, 64'(v), 64'(e_chg));
      hold   = $urandom_range(0, 3);
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!change_valid || change_value !== v) stable = 1'b0;
      end
      check({tag, "_change_stable"}, 64'(stable), 64'd1);
      change_ready = 1'b1;
      @(negedge clk);
      change_ready = 1'b0;
      check({tag, "_change_released"}, 64'(change_valid), 64'd0);
    end
    repeat (3) @(negedge clk);

    check({tag, "_dispense_cycles"}, 64'(n_disp - s_disp), 64'(e_disp));
    check({tag, "_disp_valid_cycles"}, 64'(n_dv - s_dv), 64'(e_disp));
    check({tag, "_sel_error_cycles"}, 64'(n_err - s_err), 64'(e_err));
    check({tag, "_timeout_cycles"}, 64'(n_to - s_to), 64'd0);
    check({tag, "_collected"}, 64'(saw_ready), 64'(!e_err && price != 0));
    if (e_disp) check({tag, "_disp_id"}, 64'(last_disp_id), 64'(id));
  endtask

  task automatic select_to_collect(input int id, input int price, input string tag);
    bit ok;
    price_mem[id] = 16'(price);
    stock_mem[id] = 8'd3;
    ready_mem[id] = 1'b1;
    sel_valid = 1'b1;
    sel_id    = AW'(id);
    @(negedge clk);
    sel_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cur_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_reached_collect"}, 64'(ok), 64'd1);
  endtask

  typedef struct {
    int id;
    bit rdy;
    int stock;
    int price;
    int nc;
    int c0, c1, c2;
    int cidx;
    bit e_err;
    bit e_disp;
    int e_chg;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit m_err, m_disp;
    int m_chg, id, stock, price;
    bit rdy;
    int first_err, err_cycles, to_seen, cv_val, s_disp, s_cv;
    bit cv_seen;

    vecs[0] = '{5,    1, 3, 150, 2, 100, 100, 0,  -1, 0, 1, 50};
    vecs[1] = '{7,    1, 0, 150, 1, 100, 0,   0,  -1, 1, 0, 0};
    vecs[2] = '{5,    1, 3, 150, 2, 50,  20,  0,   1, 0, 0, 70};
    vecs[3] = '{3,    1, 2, 100, 1, 100, 0,   0,  -1, 0, 1, 0};
    vecs[4] = '{12,   1, 1, 0,   0, 0,   0,   0,  -1, 0, 1, 0};
    vecs[5] = '{20,   0, 5, 50,  1, 50,  0,   0,  -1, 1, 0, 0};
    vecs[6] = '{1023, 1, 9, 300, 2, 255, 255, 0,  -1, 0, 1, 210};
    vecs[7] = '{2,    1, 4, 80,  1, 0,   0,   0,   0, 0, 0, 0};
    vecs[8] = '{40,   1, 4, 500, 2, 100, 200, 0,  -1, 0, 0, 300};
    vecs[9] = '{41,   1, 1, 1,   3, 255, 9,   9,  -1, 0, 1, 254};

    for (int a = 0; a < 1024; a++) begin
      price_mem[a] = 16'd0;
      stock_mem[a] = 8'd0;
      ready_mem[a] = 1'b0;
    end

    rstn         = 1'b0;
    sel_valid    = 1'b0;
    sel_id       = '0;
    cur_valid    = 1'b0;
    cur_value    = 8'd0;
    cancel       = 1'b0;
    change_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", 64'({cur_ready, dispense, disp_valid, sel_error, change_valid, timeout}), 64'd0);
    check("reset_change_value", 64'(change_value), 64'd0);
    check("reset_item_id", 64'(item_id), 64'd0);
    check("reset_disp_id", 64'(disp_id), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      ncoins     = vecs[v].nc;
      coins[0]   = vecs[v].c0;
      coins[1]   = vecs[v].c1;
      coins[2]   = vecs[v].c2;
      cancel_idx = vecs[v].cidx;
      run_txn(vecs[v].id, vecs[v].rdy, vecs[v].stock, vecs[v].price,
              vecs[v].e_err, vecs[v].e_disp, vecs[v].e_chg, $sformatf("vec%0d", v));
    end

    // sel_error rises on the 4th edge after the one that samples sel_valid,
    // i.e. at the 5th negedge after it is driven.
    price_mem[7] = 16'd150;
    stock_mem[7] = 8'd0;
    ready_mem[7] = 1'b1;
    sel_valid = 1'b1;
    sel_id    = AW'(7);
    first_err  = -1;
    err_cycles = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      sel_valid = 1'b0;
      if (sel_error) begin
        err_cycles++;
        if (first_err < 0) first_err = n;
      end
      if (cur_ready) err_cycles += 100;
    end
    check("sel_error_latency", 64'(first_err), 64'(LK + 2));
    check("sel_error_width", 64'(err_cycles), 64'd1);

    // Random transactions against the transaction-level model.
    for (int t = 0; t < 60; t++) begin
      id    = $urandom_range(0, 1023);
      rdy   = ($urandom_range(0, 9) != 0);
      stock = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
      price = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 600);
      ncoins = $urandom_range(1, 6);
      for (int c = 0; c < ncoins; c++)
        coins[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      cancel_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ncoins - 1) : -1;
      model(rdy, stock, price, m_err, m_disp, m_chg);
      run_txn(id, rdy, stock, price, m_err, m_disp, m_chg, $sformatf("rnd%0d", t));
    end

    // Reset in COLLECT with a balance of 80 discards everything.
    select_to_collect(5, 150, "rst_mid");
    cur_valid = 1'b1;
    cur_value = 8'd50;
    @(negedge clk);
    cur_value = 8'd30;
    @(negedge clk);
    cur_valid = 1'b0;
    @(negedge clk);
    s_disp = n_disp;
    s_cv   = n_cv;
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_flags", 64'({cur_ready, dispense, disp_valid, sel_error, change_valid, timeout}), 64'd0);
    check("rst_mid_change_value", 64'(change_value), 64'd0);
    check("rst_mid_item_id", 64'(item_id), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_dispense", 64'(n_disp - s_disp), 64'd0);
    check("rst_mid_no_change", 64'(n_cv - s_cv), 64'd0);
    check("rst_mid_idle", 64'(cur_ready), 64'd0);

    // Coin 30 followed by idle cycles in COLLECT.
    select_to_collect(9, 200, "idle_collect");
    cur_valid = 1'b1;
    cur_value = 8'd30;
    @(negedge clk);
    cur_valid = 1'b0;
    to_seen = 0;
    cv_seen = 1'b0;
    cv_val  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout) to_seen++;
      if (change_valid && !cv_seen) begin
        cv_seen = 1'b1;
        cv_val  = int'(change_value);
      end
    end
`ifdef VEND_TIMEOUT_EN
    check("timeout_pulses", 64'(to_seen), 64'd1);
    check("timeout_change_seen", 64'(cv_seen), 64'd1);
    check("timeout_change_value", 64'(cv_val), 64'd30);
    check("timeout_left_collect", 64'(cur_ready), 64'd0);
`else
    check("no_timeout_pulses", 64'(to_seen), 64'd0);
    check("no_timeout_still_collecting", 64'(cur_ready), 64'd1);
    check("no_timeout_no_change", 64'(cv_seen), 64'd0);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("no_timeout_refund_valid", 64'(change_valid), 64'd1);
    check("no_timeout_refund_value", 64'(change_value), 64'd30);
`endif
    change_ready = 1'b1;
    @(negedge clk);
    change_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_collect_done", 64'({change_valid, cur_ready}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", nchecks, nerrs);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vend_txn_ctrl.md
VEND_TXN_CTRL -- requirements
Module: vend_txn_ctrl

Interface
REQ-001 Parameters SHALL be: ITEM_ADDR_WIDTH, default 10, item index width; LOOKUP_CYCLES, default 3, item_id-to-sample wait; TIMEOUT_CYCLES, default 1000, idle-coin timeout.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  transaction clock
- rstn  in  1  asynchronous active-low reset
- sel_valid  in  1  item selection strobe
- sel_id  in  ITEM_ADDR_WIDTH  selected item
- cur_valid  in  1  currency offered
- cur_value  in  8  currency amount
- cur_ready  out  1  currency accepted this cycle
- cancel  in  1  user cancel request
- item_id  out  ITEM_ADDR_WIDTH  lookup index to item table
- avail_count  in  8  stock of item_id
- item_price  in  16  price of item_id
- item_ready  in  1  item_id is configured
- dispense  out  1  one-cycle decrement pulse to item table
- disp_valid  out  1  one-cycle product-out pulse
- disp_id  out  ITEM_ADDR_WIDTH  dispensed item
- sel_error  out  1  one-cycle reject pulse
- change_valid  out  1  change pending
- change_value  out  17  change/refund amount
- change_ready  in  1  change taken
- timeout  out  1  one-cycle timeout pulse

Function
REQ-003 FSM states SHALL be IDLE, LOOKUP, CHECK, COLLECT, DISPENSE, CHANGE.
REQ-004 IDLE: sel_valid=1 SHALL latch sel_id into item_id, clear balance, go to LOOKUP; other inputs ignored.
REQ-005 LOOKUP SHALL hold item_id and last exactly LOOKUP_CYCLES cycles, then go to CHECK (covers the table's 2-cycle read pipe).
REQ-006 CHECK: item_ready=0 or avail_count=0 SHALL pulse sel_error for 1 cycle and go to IDLE; item_price=0 SHALL go to DISPENSE; otherwise go to COLLECT.
REQ-007 cur_ready SHALL be 1 only in COLLECT; a transfer occurs when cur_valid and cur_ready are both 1; cur_valid outside COLLECT SHALL have no effect.
REQ-008 Each transfer SHALL add cur_value to the 17-bit balance in the same cycle; no overflow is possible (balance < price + 256 <= 65791).
REQ-009 COLLECT SHALL go to DISPENSE on the cycle after the updated balance >= item_price.
REQ-010 cancel in COLLECT SHALL go to CHANGE with change_value = balance, no dispense; cancel with a same-cycle transfer SHALL include that coin in the refund; cancel outside COLLECT SHALL be ignored.
REQ-011 DISPENSE SHALL last 1 cycle, asserting dispense and disp_valid for exactly that cycle with disp_id = item_id, then load change_value = balance - item_price and go to CHANGE.
REQ-012 CHANGE: change_value=0 SHALL go to IDLE next cycle with change_valid low; otherwise change_valid SHALL stay 1 with change_value stable until change_ready=1, then go to IDLE.
REQ-013 item_id SHALL remain stable from LOOKUP through CHANGE.
REQ-014 A new sel_valid outside IDLE SHALL be ignored.

Reset
REQ-015 rstn low SHALL immediately force IDLE; balance, counters, item_id, change_value = 0; cur_ready, dispense, disp_valid, sel_error, change_valid, timeout = 0; disp_id = 0.
REQ-016 Reset mid-transaction SHALL discard balance without a dispense or change output.

Configuration
REQ-017 Macro VEND_TIMEOUT_EN SHALL compile in the COLLECT timeout.
REQ-018 With VEND_TIMEOUT_EN: a counter SHALL clear on COLLECT entry and on each transfer; at TIMEOUT_CYCLES idle cycles it SHALL pulse timeout for 1 cycle and go to CHANGE with change_value = balance (0 -> IDLE per REQ-012).
REQ-019 Without VEND_TIMEOUT_EN: COLLECT SHALL wait indefinitely; timeout SHALL be tied 0.

Verification
REQ-020 Select id 5 (price 150, stock 3, ready); coins 100, 100 -> one dispense/disp_valid pulse with disp_id=5, change_valid with change_value=50 until change_ready.
REQ-021 Select id 7 with avail_count=0 -> sel_error 1-cycle pulse LOOKUP_CYCLES+1 cycles after sel_valid; no cur_ready, no dispense.
REQ-022 Select id 5, coin 50, then cancel and coin 20 in the same cycle -> change_value=70, no dispense.
REQ-023 Price 100, exact coin 100 -> dispense pulse, change_valid never asserted, IDLE next cycle.
REQ-024 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=16: coin 30 then 16 idle cycles -> timeout pulse, change_value=30; repeat without macro -> remains in COLLECT.
REQ-025 Assert rstn=0 in COLLECT with balance 80 -> all outputs 0 asynchronously, no change or dispense after release.
